// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit: one shift-add or restoring-divide step per cycle on
// operand magnitudes, with sign fix-up in the final RUN cycle before results reach HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   diff;
    logic             a_neg;
    logic             b_neg;
    logic             fits;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // op[0]=0 selects the signed variants of both MULT and DIV
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (op[1] && b == '0) ? ERR : RUN;
            RUN:  if (cnt == '0) next_state = FIN;
            FIN:  next_state = IDLE;
            ERR:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
        div0 = (state == ERR);
    end

    // Multiply: {acc,q} shifts right, q starts as the multiplier magnitude.
    // Divide: {acc,q} shifts left, q collects quotient bits while acc holds the partial remainder.
    always_comb begin
        msum  = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
        diff  = {acc, q[WIDTH-1]} - {1'b0, opnd};
        fits  = ~diff[WIDTH];
        acc_n = msum[WIDTH:1];
        q_n   = {msum[0], q[WIDTH-1:1]};
        if (is_div) begin
            acc_n = fits ? diff[WIDTH-1:0] : {acc[WIDTH-2:0], q[WIDTH-1]};
            q_n   = {q[WIDTH-2:0], fits};
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= CW'(WIDTH);
            acc    <= '0;
            q      <= op[1] ? magnitude(a, a_neg) : magnitude(b, b_neg);
            opnd   <= op[1] ? magnitude(b, b_neg) : magnitude(a, a_neg);
        end else if (state == RUN && cnt != '0) begin
            cnt <= cnt - CW'(1);
            acc <= acc_n;
            q   <= q_n;
        end
    end

    // Results only move on the RUN->FIN transition, so they hold across ERR and idle time
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (state == RUN && cnt == '0) begin
            if (is_div) begin
                hi_out <= magnitude(acc, neg_r);
                lo_out <= magnitude(q, neg_q);
            end else begin
                {hi_out, lo_out} <= negate_wide({acc, q}, neg_q);
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: constant vector table, model-checked random operations and
// hand-written sequences for mid-RUN restart, start during FIN and reset mid-operation.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         busy;
    logic         done;
    logic         div0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
    } exp_t;

    exp_t         exp_q[$];
    vec_t         tbl[$];
    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .busy   (busy),
        .done   (done),
        .div0   (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model built on native 64-bit arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        e.dz = 1'b0;
        case (o)
            2'b00: p = 64'(sx * sy);
            2'b01: p = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == '0) e.dz = 1'b1;
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == '0) e.dz = 1'b1;
                else p = {x % y, x / y};
            end
        endcase
        e.hi = e.dz ? last_hi : p[63:32];
        e.lo = e.dz ? last_lo : p[31:0];
        return e;
    endfunction

    // Scoreboard: every done/div0 pulse is matched against the oldest pending expectation
    always @(negedge clk) begin
        if (!reset && (done || div0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("div0_flag", 64'(div0), 64'(e.dz));
                check("busy_with_output", 64'(busy), 64'd0);
                check("hi_out", 64'(hi_out), 64'(e.hi));
                check("lo_out", 64'(lo_out), 64'(e.lo));
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input exp_t e, input string name);
        int n;
        int bcnt;
        bit seen;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(e);
        if (!e.dz) begin
            last_hi = e.hi;
            last_lo = e.lo;
        end
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; bcnt = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) bcnt++;
            if (done || div0) seen = 1'b1;
        end
        check({name, "_latency"}, 64'(n), e.dz ? 64'd1 : 64'(W + 2));
        check({name, "_busy_cycles"}, 64'(bcnt), e.dz ? 64'd0 : 64'(W + 1));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
    endtask

    initial begin
        exp_t e;
        logic [1:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;

        tbl.push_back('{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        tbl.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        tbl.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
        tbl.push_back('{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        tbl.push_back('{2'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0});
        tbl.push_back('{2'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0});
        tbl.push_back('{2'd0, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0});
        tbl.push_back('{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        tbl.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
        tbl.push_back('{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
        tbl.push_back('{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0});
        tbl.push_back('{2'd2, 32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000, 1'b0});
        tbl.push_back('{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0});
        tbl.push_back('{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0});
        tbl.push_back('{2'd3, 32'h00000007, 32'h00000000, 32'h0000000F, 32'h0FFFFFFF, 1'b1});
        tbl.push_back('{2'd2, 32'h00000005, 32'h00000000, 32'h0000000F, 32'h0FFFFFFF, 1'b1});
        tbl.push_back('{2'd3, 32'h00000003, 32'h00000009, 32'h00000003, 32'h00000000, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div0", 64'(div0), 64'd0);
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            e.hi = tbl[i].hi;
            e.lo = tbl[i].lo;
            e.dz = tbl[i].dz;
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, e, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i % 3 == 2) ? 32'($urandom_range(1, 40)) : $urandom;
            if (i == 7) ry = '0;
            e = model(ro, rx, ry);
            run_op(ro, rx, ry, e, $sformatf("rnd%0d", i));
        end

        // Second start while RUN must be ignored; start in FIN is dropped, accepted in IDLE
        @(negedge clk);
        op = 2'd3; a = 32'h64; b = 32'h7; start = 1'b1;
        exp_q.push_back('{32'h2, 32'hE, 1'b0});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        op = 2'd0; a = 32'h3; b = 32'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midrun");
        op = 2'd1; a = 32'h2; b = 32'h3; start = 1'b1;
        exp_q.push_back('{32'h0, 32'h6, 1'b0});
        @(posedge clk);
        #1 check("fin_start_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1 check("idle_start_accepted", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done("after_fin");
        last_hi = 32'h0;
        last_lo = 32'h6;

        // Reset at iteration 10 of a MULT discards it without a result
        @(negedge clk);
        op = 2'd0; a = 32'h7; b = 32'h9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi", 64'(hi_out), 64'd0);
        check("rst_mid_lo", 64'(lo_out), 64'd0);
        last_hi = '0;
        last_lo = '0;
        repeat (40) @(negedge clk);
        run_op(2'd3, 32'h9, 32'h3, '{32'h0, 32'h3, 1'b0}, "post_reset_divu");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
